// File: rtl/sram_byte_stream_reader.sv
// Streams a contiguous range of SRAM words out as bytes over a valid/ready port.
// Optional build macro: SRAM_READER_LITTLE_ENDIAN_EN (emit Q3..Q0 instead of Q0..Q3).
module sram_byte_stream_reader #(
  parameter int numWordAddr         = 12,
  parameter int SRAM_numBit         = 8,
  parameter int SRAM_blocks_per_row = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [numWordAddr-1:0]   base_addr,
  input  logic [numWordAddr:0]     num_words,
  output logic                     busy,
  output logic                     done,
  output logic                     CEB,
  output logic                     WEB,
  output logic [numWordAddr-1:0]   A,
  input  logic [SRAM_numBit-1:0]   Q0,
  input  logic [SRAM_numBit-1:0]   Q1,
  input  logic [SRAM_numBit-1:0]   Q2,
  input  logic [SRAM_numBit-1:0]   Q3,
  output logic [SRAM_numBit-1:0]   byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready
);

  localparam int WORD_W = SRAM_numBit * SRAM_blocks_per_row;
  localparam int IDX_W  = $clog2(SRAM_blocks_per_row);
  localparam int CNT_W  = numWordAddr + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]             state;
  logic [numWordAddr-1:0] base_q;
  logic [CNT_W-1:0]       num_q;
  logic [CNT_W-1:0]       issued;
  logic [CNT_W-1:0]       popped;
  logic                   rd_q;
  logic [WORD_W-1:0]      slot0;
  logic [WORD_W-1:0]      slot1;
  logic [1:0]             count;
  logic [IDX_W-1:0]       idx;

  logic [WORD_W-1:0]      q_word;
  logic                   accept;
  logic                   pop;
  logic                   push;
  logic                   last_pop;
  logic [WORD_W-1:0]      slot0_n;
  logic [WORD_W-1:0]      slot1_n;
  logic [1:0]             count_n;
  logic [IDX_W-1:0]       idx_n;
  logic [2:0]             occupancy;
  logic                   can_issue;
  logic [SRAM_numBit-1:0] byte_n;

  assign q_word = {Q0, Q1, Q2, Q3};

  // Stream handshake: a byte transfers at a rising edge where byte_valid && byte_ready;
  // while valid is high and ready low, byte_out and byte_valid hold their values.
  assign accept   = byte_valid & byte_ready;
  assign pop      = accept && (idx == IDX_W'(SRAM_blocks_per_row - 1));
  assign push     = rd_q;
  assign last_pop = pop && ((popped + CNT_W'(1)) == num_q);

  function automatic logic [SRAM_numBit-1:0] lane(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  i);
    lane = '0;
    for (int k = 0; k < SRAM_blocks_per_row; k++) begin
      if (i == IDX_W'(k)) begin
`ifdef SRAM_READER_LITTLE_ENDIAN_EN
        lane = w[k*SRAM_numBit +: SRAM_numBit];
`else
        lane = w[WORD_W-SRAM_numBit-k*SRAM_numBit +: SRAM_numBit];
`endif
      end
    end
  endfunction

  // Two-entry shift FIFO: slot0 is always the head word being serialized.
  always_comb begin
    slot0_n = slot0;
    slot1_n = slot1;
    count_n = count;
    if (pop) begin
      slot0_n = slot1;
      count_n = count - 2'd1;
    end
    if (push) begin
      if (count_n == 2'd0) slot0_n = q_word;
      else                 slot1_n = q_word;
      count_n = count_n + 2'd1;
    end
  end

  always_comb begin
    idx_n = idx;
    if (pop)         idx_n = '0;
    else if (accept) idx_n = idx + IDX_W'(1);
  end

  // A low CEB this cycle becomes a word on Q next cycle, so it counts as occupied.
  assign occupancy = {1'b0, count_n} + {2'b00, ~CEB};
  assign can_issue = (state == RUN) && (issued < num_q) && (occupancy < 3'd2);
  assign byte_n    = lane(slot0_n, idx_n);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued     <= '0;
      popped     <= '0;
      rd_q       <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
      count      <= 2'd0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      CEB        <= 1'b1;
      WEB        <= 1'b1;
      A          <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      WEB        <= 1'b1;
      rd_q       <= ~CEB;
      slot0      <= slot0_n;
      slot1      <= slot1_n;
      count      <= count_n;
      idx        <= idx_n;
      byte_valid <= (count_n != 2'd0);
      if (count_n != 2'd0) byte_out <= byte_n;

      case (state)
        IDLE: begin
          done <= 1'b0;
          CEB  <= 1'b1;
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_words;
            popped <= '0;
            idx    <= '0;
            if (num_words == '0) begin
              issued <= '0;
              state  <= FINISH;
              done   <= 1'b1;
            end else begin
              issued <= CNT_W'(1);
              state  <= RUN;
              busy   <= 1'b1;
              CEB    <= 1'b0;
              A      <= base_addr;
            end
          end
        end
        RUN: begin
          if (can_issue) begin
            CEB    <= 1'b0;
            A      <= base_q + issued[numWordAddr-1:0];
            issued <= issued + CNT_W'(1);
          end else begin
            CEB <= 1'b1;
          end
          if (pop) popped <= popped + CNT_W'(1);
          if (last_pop) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          CEB   <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          CEB   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_byte_stream_reader.sv
// Directed bench for sram_byte_stream_reader with a behavioural 4096x32 SRAM.
// Honours SRAM_READER_LITTLE_ENDIAN_EN for the expected byte order.
module tb_sram_byte_stream_reader;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] num_words;
  logic        busy;
  logic        done;
  logic        CEB;
  logic        WEB;
  logic [11:0] A;
  logic [7:0]  Q0, Q1, Q2, Q3;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  logic [31:0] mem [0:4095];
  logic [31:0] q_word;
  logic [7:0]  exp_q[$];

  int n_checks;
  int n_fail;

  typedef struct {
    logic [11:0] base;
    logic [12:0] num;
    int          mode;        // 0: ready=1, 1: 1-0-0-1 pattern, 2: random
    int          exp_done;    // cycle index of done after E0, -1 = not timed
    int          extra_start; // cycle to pulse an ignored start, -10 = never
  } vec_t;

  vec_t vecs[6];

  sram_byte_stream_reader dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .CEB        (CEB),
    .WEB        (WEB),
    .A          (A),
    .Q0         (Q0),
    .Q1         (Q1),
    .Q2         (Q2),
    .Q3         (Q3),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: one-cycle read latency
  always @(posedge CLK) begin
    if (!CEB) q_word <= mem[A];
  end
  assign Q0 = q_word[31:24];
  assign Q1 = q_word[23:16];
  assign Q2 = q_word[15:8];
  assign Q3 = q_word[7:0];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
`ifdef SRAM_READER_LITTLE_ENDIAN_EN
    return w[8*k +: 8];
`else
    return w[31-8*k -: 8];
`endif
  endfunction

  task automatic check_reset_values();
    check("rst_ceb", CEB, 1);
    check("rst_web", WEB, 1);
    check("rst_a", A, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  // Driver + scoreboard for one transfer; returns early with RST raised if rst_after > 0.
  task automatic run_xfer(input logic [11:0] base, input logic [12:0] n, input int mode,
                          input int exp_done, input int rst_after, input int extra_start);
    int cyc, ceb_cnt, bytes_acc, first_valid, done_cyc;
    logic prev_stall;
    logic [7:0] prev_byte;
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      w = mem[(int'(base) + i) % 4096];
      for (int k = 0; k < 4; k++) exp_q.push_back(exp_byte(w, k));
    end
    @(negedge CLK);
    start = 1'b1; base_addr = base; num_words = n; byte_ready = 1'b0;
    cyc = -1; ceb_cnt = 0; bytes_acc = 0; first_valid = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_byte = 8'h00;
    while (cyc < 300) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      start = (cyc == extra_start);
      if (start) begin base_addr = 12'h777; num_words = 13'd1; end
      check("web_high", WEB, 1);
      if (!CEB) begin
        check("addr", A, (int'(base) + ceb_cnt) % 4096);
        ceb_cnt++;
        check("outstanding_le2", (ceb_cnt - bytes_acc / 4) <= 2, 1);
      end
      if (prev_stall) begin
        check("stall_valid", byte_valid, 1);
        check("stall_byte", byte_out, prev_byte);
      end
      if (byte_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
        break;
      end
      check("busy_running", busy, (n != 0));
      if (rst_after > 0 && bytes_acc == rst_after) begin
        byte_ready = 1'b0;
        RST = 1'b1;
        return;
      end
      case (mode)
        1:       byte_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       byte_ready = 1'($urandom_range(0, 1));
        default: byte_ready = 1'b1;
      endcase
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 1, 0);
        else check("byte", byte_out, exp_q.pop_front());
        bytes_acc++;
      end
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      check("timeout", 0, 1);
    end else begin
      check("ceb_cycles", ceb_cnt, n);
      check("byte_count", bytes_acc, 4 * int'(n));
      check("bytes_left", exp_q.size(), 0);
      if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
      if (n != 0) check("first_valid", first_valid, 2);
      else        check("no_valid", first_valid, -1);
    end
    @(posedge CLK);
    @(negedge CLK);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ceb", CEB, 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    RST = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; byte_ready = 1'b0;
    for (int i = 0; i < 4096; i++)
      mem[i] = {8'(i), 8'(i >> 4) ^ 8'hC3, 8'(~i), 8'(i * 7)};
    mem[12'h010] = 32'h11223344;
    mem[12'h011] = 32'h55667788;
    mem[12'h200] = 32'hA1B2C3D4;

    vecs[0] = '{base: 12'h010, num: 13'd2, mode: 0, exp_done: 10, extra_start: -10};
    vecs[1] = '{base: 12'hFFF, num: 13'd3, mode: 0, exp_done: 14, extra_start: -10};
    vecs[2] = '{base: 12'h100, num: 13'd4, mode: 1, exp_done: -1, extra_start: 5};
    vecs[3] = '{base: 12'h020, num: 13'd0, mode: 0, exp_done: 0,  extra_start: -10};
    vecs[4] = '{base: 12'h200, num: 13'd1, mode: 0, exp_done: 6,  extra_start: -10};
    vecs[5] = '{base: 12'hFFE, num: 13'd5, mode: 2, exp_done: -1, extra_start: -10};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_values();
    RST = 1'b0;
    @(negedge CLK);

    for (int v = 0; v < 6; v++)
      run_xfer(vecs[v].base, vecs[v].num, vecs[v].mode, vecs[v].exp_done, 0, vecs[v].extra_start);

    // Reset after 5 bytes of a 4-word transfer, then a clean retry.
    run_xfer(12'h400, 13'd4, 0, -1, 5, -10);
    @(posedge CLK);
    @(negedge CLK);
    check_reset_values();
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("post_rst_done", done, 0);
      check("post_rst_valid", byte_valid, 0);
      check("post_rst_ceb", CEB, 1);
    end
    run_xfer(12'h400, 13'd4, 0, 18, 0, -10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_byte_stream_reader.md
# sram_byte_stream_reader

Streams a contiguous range of 32-bit words out of the 4096x32 byte-lane SRAM wrapper as a byte stream with valid/ready handshake. It drives the wrapper's CEB/WEB/A, takes Q0..Q3 one cycle later and buffers up to two words, then serializes them one byte per accepted transfer. It sits directly downstream of the SRAM wrapper, feeding the byte-wide datapath consumers, and owns the wrapper's read port for the duration of a transfer.

## Interface
Parameters:
- numWordAddr, 12, SRAM word address width (4096 words)
- SRAM_numBit, 8, width of each byte lane Q0..Q3 and of byte_out
- SRAM_blocks_per_row, 4, byte lanes per word

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  numWordAddr  first word address, captured on start
- num_words  in  numWordAddr+1  word count 0..4096, captured on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the last byte is accepted
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low; held 1 (read-only)
- A  out  numWordAddr  SRAM word address
- Q0..Q3  in  SRAM_numBit each  SRAM byte lanes; Q0 = word bits 31:24
- byte_out  out  SRAM_numBit  stream data
- byte_valid  out  1  stream data valid
- byte_ready  in  1  consumer accepts when valid && ready at rising edge

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE: start=1 captures base_addr, num_words; clears counters. num_words=0 -> FINISH directly (no SRAM access); else -> RUN.
- RUN: issue read (CEB=0, A=base_addr+issued mod 4096) in any cycle where issued < num_words and (buffered + in_flight) < 2. Address wraps 4095 -> 0.
- In-flight read: Q0..Q3 captured into the 2-entry word buffer on the edge after the SRAM samples CEB=0. Word buffer is a 2-deep FIFO.
- Serializer: head word emits Q0, Q1, Q2, Q3 in order; byte index advances on each accepted transfer; head word popped after Q3 accepted.
- RUN -> FINISH when all num_words words issued, captured, and all bytes accepted.
- FINISH: done=1 for exactly one cycle, busy=0 the same cycle, -> IDLE.
- start while busy ignored. byte_ready with byte_valid=0 has no effect.
- byte_out/byte_valid held stable while byte_valid && !byte_ready.
- RST (any state, mid-transfer included): all state cleared next edge, in-flight read discarded, no done pulse.

## Timing
- Reset values: CEB=1, WEB=1, A=0, byte_out=0, byte_valid=0, busy=0, done=0.
- All outputs registered.
- start sampled at edge E0 -> CEB=0, A=base_addr during cycle E0..E1 -> SRAM samples at E1 -> buffer captures at E2 -> byte_valid=1 after E2 (2-cycle start-to-data latency).
- With byte_ready held 1: one byte per cycle sustained, no bubbles between words; N words finish in 4N+2 cycles after E0, done asserted the cycle after the last byte is accepted.
- Backpressure: buffer full (2 words) plus no in-flight -> CEB held 1; reads resume the cycle after a slot frees.
- CEB low for exactly num_words cycles per transfer.

## Configuration
- SRAM_READER_LITTLE_ENDIAN_EN defined: each word emitted Q3, Q2, Q1, Q0 (least-significant byte first).
- Undefined (default): Q0, Q1, Q2, Q3 (most-significant byte first).

## Test plan
- base_addr=0x010, num_words=2, SRAM words 0x11223344, 0x55667788, ready=1 -> bytes 11 22 33 44 55 66 77 88 on consecutive cycles, first valid 2 cycles after start, done one cycle after last; CEB low exactly 2 cycles, A=0x010,0x011.
- base_addr=0xFFF, num_words=3 -> A sequence 0xFFF, 0x000, 0x001; 12 bytes in order.
- num_words=4, ready toggling 1-0-0-1 pattern -> no byte lost/duplicated, byte_out stable while stalled, never more than 2 words buffered+in-flight.
- num_words=0 -> done pulse 1 cycle after start, CEB never low, byte_valid never high.
- RST asserted after 5 bytes of a 4-word transfer -> next cycle all outputs at reset values, no done; fresh start then completes correctly.
- SRAM_READER_LITTLE_ENDIAN_EN defined, word 0xA1B2C3D4 -> bytes D4 C3 B2 A1.
